// File: rtl/ahb_bridge_pkg.sv
// ahb_bridge_pkg: AHB transfer-type and response encodings shared by the bridge blocks.
package ahb_bridge_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
endpackage

// File: rtl/ahb_bridge_arbiter_rr_pick.sv
// rr_pick: round-robin priority encoder searching upward from last+1, with last itself tried last.
module rr_pick #(
  parameter int NUM_M = 3,
  parameter int MW    = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [MW-1:0]    last,
  output logic [MW-1:0]    winner,
  output logic             any
);
  always_comb begin
    winner = '0;
    any    = |req;
    for (int k = NUM_M; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_M]) winner = MW'((int'(last) + k) % NUM_M);
    end
  end
endmodule

// File: rtl/ahb_bridge_arbiter.sv
// ahb_bridge_arbiter: round-robin sharing of the bridge AHB slave port between NUM_M masters.
module ahb_bridge_arbiter
  import ahb_bridge_pkg::*;
#(
  parameter int NUM_M    = 3,
  parameter int MW       = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic [NUM_M-1:0]    hbusreq,
  input  logic [2*NUM_M-1:0]  htrans_m,
  input  logic [32*NUM_M-1:0] haddr_m,
  input  logic [NUM_M-1:0]    hwrite_m,
  input  logic [32*NUM_M-1:0] hwdata_m,
  input  logic                hready,
  output logic [NUM_M-1:0]    hgrant,
  output logic [MW-1:0]       hmaster,
  output logic [1:0]          htrans,
  output logic [31:0]         haddr,
  output logic                hwrite,
  output logic [31:0]         hwdata,
  output logic                hreadyin
);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  logic [MW-1:0] hmaster_d, last, winner, next_owner;
  logic [HW-1:0] hold_cnt;
  logic          any, others, hold_hit, arb_ok, beat;
  rr_pick #(.NUM_M(NUM_M), .MW(MW)) u_pick (
    .req(hbusreq), .last(last), .winner(winner), .any(any)
  );
  assign htrans     = htrans_m[2*int'(hmaster) +: 2];
  assign haddr      = haddr_m[32*int'(hmaster) +: 32];
  assign hwrite     = hwrite_m[hmaster];
  assign hwdata     = hwdata_m[32*int'(hmaster_d) +: 32];
  assign hreadyin   = hready;
  assign others     = |(hbusreq & ~(NUM_M'(1) << hmaster));
  assign hold_hit   = (MAX_HOLD != 0) && (int'(hold_cnt) >= MAX_HOLD - 1) && others;
  assign beat       = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  assign arb_ok     = hready && ((htrans == HTRANS_IDLE) || (htrans == HTRANS_NONSEQ) || !hbusreq[hmaster] || hold_hit);
  assign next_owner = any ? winner : '0;
  // Wait states (hready=0) freeze every piece of arbitration state.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hmaster   <= '0;
      hgrant    <= NUM_M'(1);
      hmaster_d <= '0;
      hold_cnt  <= '0;
      last      <= '0;
    end else if (hready) begin
      hmaster_d <= hmaster;
      if (arb_ok && next_owner != hmaster) begin
        hmaster  <= next_owner;
        hgrant   <= NUM_M'(1) << next_owner;
        hold_cnt <= '0;
      end else if (beat && int'(hold_cnt) < MAX_HOLD) hold_cnt <= hold_cnt + 1'b1;
      if (arb_ok && any) last <= winner;
    end
  end
endmodule
